// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: default geometry
// and the clear-FSM state encoding.
package regfile_mp_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;

    typedef logic [0:0] fsm_state_t;

    localparam fsm_state_t CLEAR = 1'b0;
    localparam fsm_state_t RUN   = 1'b1;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer for regfile_mp. Owns the CLEAR/RUN state, the clear
// index counter and the registered ready flag. After reset (or a soft
// clear request from RUN) it walks every entry once, one per cycle, and
// returns to RUN on the same edge that zeroes the last entry.
module regfile_clear_fsm
    import regfile_mp_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    output logic                  clearing,
    output logic [ADDR_WIDTH-1:0] clr_idx,
    output logic                  ready
);

    // One extra bit so the count past the last entry never aliases index 0.
    localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) - 1);

    fsm_state_t            state_reg;
    fsm_state_t            state_next;
    logic [ADDR_WIDTH:0]   cnt_reg;
    logic [ADDR_WIDTH:0]   cnt_next;
    logic                  ready_reg;
    logic                  ready_next;

    // Next-state logic: sweep while clearing, accept a clear request in RUN.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (state_reg == CLEAR) begin
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == CNT_LAST) begin
                state_next = RUN;
            end
        end else if (clr) begin
            state_next = CLEAR;
            cnt_next   = '0;
        end
        ready_next = (state_next == RUN);
    end

    // State registers; reset restarts the sweep from index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= CLEAR;
            cnt_reg   <= '0;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ready_reg <= ready_next;
        end
    end

    assign clearing = (state_reg == CLEAR);
    assign clr_idx  = cnt_reg[ADDR_WIDTH-1:0];
    assign ready    = ready_reg;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: one write port, NUM_RD (1..4) combinational
// read ports, index 0 hardwired to zero, and a self-clearing sweep after
// reset or on a soft clear request. Reads return zero during reset and
// while the sweep runs.
// Optional build macro: REGFILE_BYPASS_EN forwards same-cycle write data
// to any read port addressing the register being written.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int NUM_RD     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic                         ready
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic                  clearing;
    logic [ADDR_WIDTH-1:0] clr_idx;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    regfile_clear_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_fsm (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .clearing (clearing),
        .clr_idx  (clr_idx),
        .ready    (ready)
    );

    // Storage update: the sweep owns the write port while clearing, so
    // user writes are dropped then; writes to index 0 are never stored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clearing) begin
                mem[clr_idx] <= '0;
            end else if (wr_en && (wr_addr != '0)) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_WIDTH-1:0] addr;
            logic [DATA_WIDTH-1:0] word;

            assign addr = rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];

            // Read mux for one port; zero masking takes priority over all.
            always_comb begin
                word = mem[addr];
`ifdef REGFILE_BYPASS_EN
                if (wr_en && (wr_addr == addr)) begin
                    word = wr_data;
                end
`else
`endif
                if (rst || clearing || (addr == '0)) begin
                    word = '0;
                end
            end

            assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = word;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (default geometry, two read ports).
// Table-driven vectors, hand sequences for reset/clear timing, and a
// randomized phase checked against an array-based reference model.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              clr;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic              ready;

    int checks = 0;
    int errors = 0;

    // Reference model: contents plus a countdown of clearing cycles left.
    logic [DW-1:0] mdl_mem [DEPTH];
    bit            mdl_busy = 1'b1;
    int            mdl_left = DEPTH;

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] r0;
        logic [AW-1:0] r1;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    regfile_mp #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_RD     (NR)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .ready   (ready)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    function automatic logic [DW-1:0] mdl_rd(input logic [AW-1:0] a);
        if (rst || mdl_busy || a == 0) return '0;
        if (BYP && wr_en && wr_addr == a) return wr_data;
        return mdl_mem[a];
    endfunction

    // Model behaviour at a rising edge, from the inputs held across it.
    task automatic mdl_edge();
        if (rst) begin
            mdl_busy = 1'b1;
            mdl_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
        end else if (mdl_busy) begin
            mdl_left--;
            if (mdl_left == 0) mdl_busy = 1'b0;
        end else begin
            if (wr_en && wr_addr != 0) mdl_mem[wr_addr] = wr_data;
            if (clr) begin
                mdl_busy = 1'b1;
                mdl_left = DEPTH;
                for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        mdl_edge();
        #1;
    endtask

    task automatic drive(input bit r, input bit c, input bit we, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        rst     = r;
        clr     = c;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_addr = {r1, r0};
        #2;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_rd0"}, rd_data[DW-1:0], mdl_rd(rd_addr[AW-1:0]));
        chk({tag, "_rd1"}, rd_data[2*DW-1:DW], mdl_rd(rd_addr[2*AW-1:AW]));
        chk({tag, "_ready"}, {31'd0, ready}, {31'd0, !mdl_busy});
    endtask

    // Count edges until ready is seen high; bounded so a stuck DUT still ends.
    task automatic wait_ready(input string name, input int exp_n);
        int n = 0;
        while (ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk(name, DW'(n), DW'(exp_n));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;

        // Reset: three cycles high, outputs held at zero throughout.
        drive(1, 0, 1, 5'd5, 32'hFFFF_0000, 5'd5, 5'd9);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst%0d_ready", i), {31'd0, ready}, 32'd0);
            chk($sformatf("rst%0d_rd0", i), rd_data[DW-1:0], 32'd0);
            chk($sformatf("rst%0d_rd1", i), rd_data[2*DW-1:DW], 32'd0);
        end
        drive(0, 0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
        wait_ready("reset_ready_latency", 32);
        for (int i = 0; i < DEPTH / 2; i++) begin
            drive(0, 0, 0, 5'd0, 32'd0, 5'(2 * i), 5'(2 * i + 1));
            chk($sformatf("init_x%0d", 2 * i), rd_data[DW-1:0], 32'd0);
            chk($sformatf("init_x%0d", 2 * i + 1), rd_data[2*DW-1:DW], 32'd0);
        end

        // Directed vectors: write/read, x0 protection, same-cycle forwarding.
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd0,  32'h0, 32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd5,  32'h0, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0, 32'h0};
        vecs[4]  = '{1'b1, 5'd7,  32'h11111111, 5'd7,  5'd5,  BYP ? 32'h11111111 : 32'h0, 32'hDEADBEEF};
        vecs[5]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd7,  BYP ? 32'hA5A5A5A5 : 32'h11111111,
                     BYP ? 32'hA5A5A5A5 : 32'h11111111};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd5,  32'hA5A5A5A5, 32'hDEADBEEF};
        vecs[7]  = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd1,  BYP ? 32'hFFFFFFFF : 32'h0, 32'h0};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[9]  = '{1'b1, 5'd5,  32'h0,        5'd30, 5'd5,  32'h0, BYP ? 32'h0 : 32'hDEADBEEF};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd7,  32'h0, 32'hA5A5A5A5};
        for (int i = 0; i < 11; i++) begin
            drive(0, 0, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].r0, vecs[i].r1);
            chk($sformatf("vec%0d_rd0", i), rd_data[DW-1:0], vecs[i].e0);
            chk($sformatf("vec%0d_rd1", i), rd_data[2*DW-1:DW], vecs[i].e1);
            tick();
        end

        // Soft clear with a same-cycle write; writes during the sweep drop.
        drive(0, 0, 1, 5'd3, 32'h11, 5'd3, 5'd4);
        tick();
        drive(0, 1, 1, 5'd4, 32'h22, 5'd3, 5'd4);
        chk("sclr_pre_x3", rd_data[DW-1:0], 32'h11);
        tick();
        chk("sclr_ready_drop", {31'd0, ready}, 32'd0);
        drive(0, 1, 1, 5'd3, 32'h99, 5'd3, 5'd4);
        chk("sclr_busy_x3", rd_data[DW-1:0], 32'd0);
        chk("sclr_busy_x4", rd_data[2*DW-1:DW], 32'd0);
        wait_ready("sclr_ready_latency", 32);
        drive(0, 0, 0, 5'd0, 32'd0, 5'd3, 5'd4);
        chk("sclr_post_x3", rd_data[DW-1:0], 32'd0);
        chk("sclr_post_x4", rd_data[2*DW-1:DW], 32'd0);

        // Reset at clear cycle 10 restarts the full sweep.
        drive(0, 1, 0, 5'd0, 32'd0, 5'd0, 5'd0);
        tick();
        drive(0, 0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
        for (int i = 0; i < 10; i++) tick();
        drive(1, 0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
        tick();
        chk("midclr_rst_ready", {31'd0, ready}, 32'd0);
        drive(0, 0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
        wait_ready("midclr_ready_latency", 32);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            logic [AW-1:0] wa;
            logic [AW-1:0] r0;
            logic [AW-1:0] r1;
            wa = AW'($urandom);
            r0 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
            r1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
            drive($urandom_range(0, 299) == 0, $urandom_range(0, 49) == 0,
                  1'($urandom_range(0, 1)), wa, $urandom, r0, r1);
            chk_model($sformatf("rand%0d", i));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning register data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, meaning register address width; depth is 2**ADDR_WIDTH.
REQ-003 SHALL have parameter NUM_RD, default 2, meaning number of independent read ports (1..4).
REQ-004 SHALL have one clock and a synchronous, active-high reset, named as in the rest of the codebase.
REQ-005 SHALL have these ports, one per line as name, direction, width, meaning:
  clk  input  1  clock; all state changes on its rising edge.
  rst  input  1  synchronous active-high reset.
  clr  input  1  soft-clear request; sampled only in RUN.
  wr_en  input  1  write enable.
  wr_addr  input  ADDR_WIDTH  write register index.
  wr_data  input  DATA_WIDTH  write data.
  rd_addr  input  NUM_RD*ADDR_WIDTH  packed read indices; port k is slice k.
  rd_data  output  NUM_RD*DATA_WIDTH  packed read data; port k is slice k.
  ready  output  1  high in RUN, low while clearing.

Function
REQ-006 SHALL implement a two-state FSM: CLEAR and RUN.
REQ-007 In CLEAR, SHALL write zero to entry clr_cnt each cycle and increment clr_cnt. SHALL go to RUN on the cycle after entry 2**ADDR_WIDTH-1 is zeroed. Clearing takes exactly 2**ADDR_WIDTH cycles after rst falls.
REQ-008 In RUN with clr=1, SHALL enter CLEAR next cycle with clr_cnt=0. A write in that same cycle SHALL still commit.
REQ-009 In CLEAR, SHALL ignore wr_en and clr. All rd_data slices SHALL read 0.
REQ-010 In RUN with wr_en=1 and wr_addr!=0, SHALL store wr_data at the rising edge. Writes to index 0 SHALL be discarded.
REQ-011 Reads SHALL be combinational (zero latency) from storage. Index 0 SHALL always read 0 on every port.
REQ-012 Any number of ports SHALL be able to read the same index in the same cycle with identical results.
REQ-013 clr_cnt SHALL be ADDR_WIDTH+1 bits wide so the terminal count does not wrap to 0.
REQ-014 ready SHALL be a registered output, high exactly when the state is RUN.

Reset
REQ-015 While rst=1, at each edge: state=CLEAR, clr_cnt=0, ready=0.
REQ-016 rst asserted mid-clear SHALL restart clearing from index 0.
REQ-017 rst SHALL override clr and wr_en.
REQ-018 rd_data SHALL be all zero while rst=1.

Configuration
REQ-019 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
  Defined: in RUN, a read port whose rd_addr equals wr_addr (nonzero) while wr_en=1 SHALL return wr_data in the same cycle.
  Undefined: that port SHALL return the old stored value.

Structure
REQ-020 DATA_WIDTH/ADDR_WIDTH defaults and the state encoding constants (CLEAR=1'b0, RUN=1'b1) SHALL live in the shared riscv definitions header.
REQ-021 One sub-module, regfile_clear_fsm, SHALL own the state, clr_cnt and ready.
REQ-022 The storage array and read muxes SHALL stay in regfile_mp.

Verification
REQ-023 Reset sequence: rst=1 for 3 cycles, then release. ready SHALL rise exactly 32 cycles later (ADDR_WIDTH=5), and all 32 entries SHALL read 0.
REQ-024 Write then read: write 0xDEADBEEF to x5, then set rd_addr0=5 and rd_addr1=5 next cycle. Both ports SHALL show 0xDEADBEEF.
REQ-025 x0 protection: write 0x12345678 to x0. Port 0 reading x0 SHALL show 0.
REQ-026 Same-cycle forwarding: wr_en=1, wr_addr=7, wr_data=0xA5A5A5A5 with rd_addr0=7. Port 0 SHALL show 0xA5A5A5A5 when REGFILE_BYPASS_EN is defined, else the prior value.
REQ-027 Soft clear: with x3=0x11, pulse clr together with a write of 0x22 to x4. ready SHALL drop next cycle. Writes during CLEAR SHALL be ignored. After 32 cycles, x3 and x4 SHALL both read 0.
REQ-028 Reset mid-clear: assert rst at clear cycle 10. ready SHALL rise 32 cycles after rst falls.
